// File: rtl/set_pkg.sv
// rtl/set_pkg.sv - shared types and constants for the set/edit controller
package set_pkg;

    // Field selector values driven on field_sel.
    typedef enum logic [2:0] {
        FIELD_NONE  = 3'd0,
        FIELD_HOUR  = 3'd1,
        FIELD_MIN   = 3'd2,
        FIELD_SEC   = 3'd3,
        FIELD_DAY   = 3'd4,
        FIELD_MONTH = 3'd5,
        FIELD_YEAR  = 3'd6
    } field_e;

    // Edit FSM states; F0..F2 are the three fields of the latched group.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_F0   = 2'd1,
        ST_F1   = 2'd2,
        ST_F2   = 2'd3
    } state_e;

    // Display digits blanked for each field (bit 7 = leftmost digit).
    localparam logic [7:0] MASK_HOUR_DAY = 8'hC0;
    localparam logic [7:0] MASK_MIN_MON  = 8'h30;
    localparam logic [7:0] MASK_SEC      = 8'h0C;
    localparam logic [7:0] MASK_YEAR     = 8'h0F;

    // Auto-repeat timing: first repeat after the delay, then every period.
    localparam int AR_DELAY_CYCLES  = 25_000_000;
    localparam int AR_PERIOD_CYCLES = 5_000_000;

    // Field shown for an FSM state; cal = 1 selects the calendar group.
    function automatic field_e field_of(input state_e st, input logic cal);
        case (st)
            ST_F0:   field_of = cal ? FIELD_DAY   : FIELD_HOUR;
            ST_F1:   field_of = cal ? FIELD_MONTH : FIELD_MIN;
            ST_F2:   field_of = cal ? FIELD_YEAR  : FIELD_SEC;
            default: field_of = FIELD_NONE;
        endcase
    endfunction

    function automatic logic [7:0] digit_mask(input field_e f);
        case (f)
            FIELD_HOUR, FIELD_DAY:  digit_mask = MASK_HOUR_DAY;
            FIELD_MIN, FIELD_MONTH: digit_mask = MASK_MIN_MON;
            FIELD_SEC:              digit_mask = MASK_SEC;
            FIELD_YEAR:             digit_mask = MASK_YEAR;
            default:                digit_mask = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - sync, debounce and press-edge detect for one active-low button
//   clk, rst : clock, asynchronous active-high reset
//   btn      : raw active-low button (asynchronous)
//   press    : one-cycle pulse on each accepted press (released -> pressed)
//   held     : debounced level, 1 while the button is accepted as pressed
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press,
    output logic held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          accept;

    // The synchronized level must differ from the accepted level for
    // DEBOUNCE_CYCLES consecutive cycles before it is taken.
    assign accept = (sync2 != level) && (cnt == CNT_LAST);
    assign held   = ~level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= accept && !sync2;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/set_mode_ctrl.sv
// rtl/set_mode_ctrl.sv - button-driven edit sequencer for the clock/calendar datapath
//   clk, rst          : clock, asynchronous active-high reset
//   sw_mode           : 0 = clock group, 1 = calendar group (asynchronous level)
//   butt_change/increase/decrease : raw active-low pushbuttons
//   edit_active       : high in any edit state
//   field_sel         : selected field (0 none, 1..6 hour..year)
//   inc_pulse/dec_pulse : one-cycle adjust commands for field_sel
//   run_en            : low while a clock-group field is being edited
//   blink_mask        : digits to blank for the blinking field
//   Optional: SET_AUTO_REPEAT_EN enables hold-to-repeat on increase/decrease.
module set_mode_ctrl
    import set_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 12_500_000,
    parameter int TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_mode,
    input  logic       butt_change,
    input  logic       butt_increase,
    input  logic       butt_decrease,
    output logic       edit_active,
    output logic [2:0] field_sel,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       run_en,
    output logic [7:0] blink_mask
);

    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic chg_press, inc_press, dec_press;
    logic chg_held, inc_held, dec_held;
    logic mode_meta, mode_sync;
    logic rpt_inc, rpt_dec;
    logic inc_ev, dec_ev, any_ev;

    state_e        state_q, state_d;
    logic          group_q, group_d;
    logic          inc_d, dec_d;
    logic [BW-1:0] blink_cnt, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [TW-1:0] tmo_cnt;
    field_e        field_d;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chg (
        .clk(clk), .rst(rst), .btn(butt_change), .press(chg_press), .held(chg_held));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .rst(rst), .btn(butt_increase), .press(inc_press), .held(inc_held));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk(clk), .rst(rst), .btn(butt_decrease), .press(dec_press), .held(dec_held));

`ifdef SET_AUTO_REPEAT_EN
    localparam int RW = $clog2(AR_DELAY_CYCLES + 1);
    localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(AR_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(AR_PERIOD_CYCLES - 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_first;
    logic          rpt_hold;
    logic          rpt_tick;

    // Only a single held adjust button repeats; holding both repeats nothing.
    assign rpt_hold = (state_q != ST_IDLE) && (inc_held ^ dec_held);
    assign rpt_tick = rpt_hold &&
                      (rpt_cnt == (rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST));
    assign rpt_inc  = rpt_tick & inc_held;
    assign rpt_dec  = rpt_tick & dec_held;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (!rpt_hold) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_tick) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end

    wire unused_held = chg_held;
`else
    assign rpt_inc = 1'b0;
    assign rpt_dec = 1'b0;

    wire unused_held = chg_held ^ inc_held ^ dec_held;
`endif

    assign inc_ev = inc_press | rpt_inc;
    assign dec_ev = dec_press | rpt_dec;
    assign any_ev = chg_press | inc_ev | dec_ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_meta <= 1'b0;
            mode_sync <= 1'b0;
        end else begin
            mode_meta <= sw_mode;
            mode_sync <= mode_meta;
        end
    end

    // Next state, adjust commands and blink phase.
    always_comb begin
        state_d     = state_q;
        group_d     = group_q;
        inc_d       = 1'b0;
        dec_d       = 1'b0;
        blink_cnt_d = blink_cnt;
        phase_d     = phase_q;

        if (state_q == ST_IDLE) begin
            if (chg_press) begin
                state_d = ST_F0;
                group_d = mode_sync;
            end
        end else if ((mode_sync != group_q) || (tmo_cnt == TMO_LAST)) begin
            state_d = ST_IDLE;
        end else if (chg_press) begin
            // change wins over a coincident adjust event
            case (state_q)
                ST_F0:   state_d = ST_F1;
                ST_F1:   state_d = ST_F2;
                default: state_d = ST_IDLE;
            endcase
        end else if (inc_ev ^ dec_ev) begin
            inc_d = inc_ev;
            dec_d = dec_ev;
        end

        // Any state change restarts the blink with digits visible.
        if (state_d != state_q) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt + 1'b1;
        end

        field_d = field_of(state_d, group_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            group_q     <= 1'b0;
            blink_cnt   <= '0;
            phase_q     <= 1'b0;
            tmo_cnt     <= '0;
            edit_active <= 1'b0;
            field_sel   <= 3'd0;
            inc_pulse   <= 1'b0;
            dec_pulse   <= 1'b0;
            run_en      <= 1'b1;
            blink_mask  <= 8'h00;
        end else begin
            state_q     <= state_d;
            group_q     <= group_d;
            blink_cnt   <= blink_cnt_d;
            phase_q     <= phase_d;
            edit_active <= (state_d != ST_IDLE);
            field_sel   <= field_d;
            inc_pulse   <= inc_d;
            dec_pulse   <= dec_d;
            run_en      <= !((state_d != ST_IDLE) && !group_d);
            blink_mask  <= phase_d ? digit_mask(field_d) : 8'h00;

            if ((state_q == ST_IDLE) || (state_d == ST_IDLE) || any_ev) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule
